mod_muldiv_unit: RTL and testbench
==================================

// Module: mod_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, downstream of the ALU B-operand mux.
//  Consumes alu_a (rs1_data) and alu_b (mux output) and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Results go into architectural HI/LO registers; the hazard unit stalls the pipe while busy is high.
// PARAMETERS
//  WIDTH    32  operand/HI/LO width; must be even and >= 4
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; clears all state
//  alu_a     in   WIDTH  operand A (dividend / multiplicand / MTHI/MTLO source)
//  alu_b     in   WIDTH  operand B (divisor / multiplier), from the ALU B mux
//  md_op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  start     in   1      one-cycle request; sampled only in IDLE
//  flush     in   1      abort the in-flight operation
//  busy      out  1      high whenever state != IDLE
//  done      out  1      one-cycle pulse; hi/lo hold the new result in the same cycle
//  hi        out  WIDTH  HI register (remainder / upper product)
//  lo        out  WIDTH  LO register (quotient / lower product)
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: start with md_op in 000..011 latches operands/op and goes to RUN next edge.
//     Signed ops latch |a| and |b|, plus sign flags.
//   IDLE: start with MTHI/MTLO writes hi or lo from alu_a at the next edge.
//     done pulses in that same following cycle; busy stays 0.
//   IDLE: start with an undefined md_op is ignored (no done, no state change).
//   RUN: exactly WIDTH cycles.
//     Multiply is one shift-add step per cycle into a 2*WIDTH accumulator.
//     Divide is one restoring step per cycle (shift, trial subtract, set quotient bit).
//   FIX: one cycle. Conditional two's-complement negate.
//     Product is negated when sign_a ^ sign_b.
//     Quotient is negated when sign_a ^ sign_b; remainder takes the sign of the dividend.
//     hi/lo are written at the end of FIX.
//   DONE: one cycle, done=1, busy=1. Returns to IDLE.
//  Latency: start sampled at edge N; done=1 during cycle after edge N+WIDTH+2 (34 for WIDTH=32).
//  Next start is accepted in the first IDLE cycle after DONE.
//  start while busy: ignored, no queuing.
//  flush in any state: next edge goes to IDLE; hi/lo unchanged; no done.
//  flush+start in the same cycle: flush wins and start is dropped.
//  MULT is a signed WIDTH x WIDTH -> 2*WIDTH product, {hi,lo}; MULTU is the unsigned version.
//  Most-negative operand: |0x8000_0000| is 0x8000_0000 as unsigned; results stay exact.
//   Exact results include MULT(0x8000_0000, 0x8000_0000) = 0x4000_0000_0000_0000.
//   DIV(0x8000_0000, -1) gives lo=0x8000_0000, hi=0 (wraps).
//  hi/lo change only on a FIX exit or an MTHI/MTLO write.
// CONFIGURATION
//  MULDIV_DIV0_TRAP_EN defined:
//   Adds output div_zero (1 bit, reset 0).
//   DIV/DIVU with alu_b==0 goes IDLE -> DONE directly (done at edge N+1).
//   In that case hi/lo are unchanged and div_zero=1 for the done cycle only.
//  MULDIV_DIV0_TRAP_EN undefined:
//   No div_zero port; divide by zero runs the full latency.
//   DIVU result: lo=all ones, hi=alu_a.
//   DIV result: hi=alu_a, lo = alu_a<0 ? 1 : all ones.
// STRUCTURE
//  Package pkg_muldiv holds:
//   md_op codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
//   FSM state encoding (ST_IDLE, ST_RUN, ST_FIX, ST_DONE).
//  Sub-module mod_muldiv_negate: combinational conditional two's-complement, parameterised width.
//   Instantiated for operand absolute values and for FIX-stage result correction.
// TESTING
//  MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> done at +34, hi=0xFFFF_FFFE lo=0x0000_0001.
//  MULT a=-7 b=3 -> hi=0xFFFF_FFFF lo=0xFFFF_FFEB.
//  DIV a=-7 b=2 -> lo=0xFFFF_FFFD (-3) hi=0xFFFF_FFFF (-1).
//  DIVU a=100 b=7 -> lo=14 hi=2.
//  MTHI a=0x1234_5678 -> hi=0x1234_5678 and done one cycle later; busy stays 0; lo unchanged.
//  Second start while busy is ignored.
//  flush at cycle +10 of a DIV -> no done, hi/lo keep their old values, busy=0 next cycle.
//  reset asserted mid-RUN -> busy=0 and hi=lo=0 immediately, without waiting for a clock edge.
//  DIV by zero with a=5, checked under both macro settings.
//   Trap on: done at +1, div_zero=1, hi/lo unchanged.
//   Trap off: done at +34, lo=0xFFFF_FFFF, hi=5.

Source files
------------

// File: rtl/mod_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds md_op encodings, FSM state encoding and small op-decode helpers.
// No logic or ports; imported by mod_muldiv_unit and mod_muldiv_negate.
package pkg_muldiv;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } st_e;

    // MULT/MULTU/DIV/DIVU occupy codes 000..011.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Both divide codes have bit 1 set within the arithmetic group.
    function automatic logic op_is_div(input logic [2:0] op);
        return (op[2] == 1'b0) && op[1];
    endfunction

endpackage

// File: rtl/mod_muldiv_unit_negate.sv
// Combinational conditional two's-complement negate (module mod_muldiv_negate).
// Zero latency; no flow control.
// Ports: en (negate when high), value (input word), result (value or -value).
module mod_muldiv_negate
    import pkg_muldiv::*;
#(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    assign result = en ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/mod_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit feeding architectural HI/LO.
// Latency: arithmetic ops pulse done WIDTH+2 edges after start; MTHI/MTLO after 1 edge.
// Backpressure: none; busy stalls the pipe, start while busy is dropped, flush aborts.
// Ports: clk, reset (async high), alu_a/alu_b operands, md_op, start, flush,
//        busy, done, hi, lo, and div_zero when MULDIV_DIV0_TRAP_EN is defined.
// MULDIV_DIV0_TRAP_EN: divide by zero skips the iteration and flags div_zero instead.
module mod_muldiv_unit
    import pkg_muldiv::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [2:0]       md_op,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_TRAP_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    st_e                 state;
    st_e                 state_nxt;
    logic [CNT_W-1:0]    cnt;
    // acc holds {upper product, lower product/multiplier} or {remainder, quotient}.
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH-1:0]    opnd;      // multiplicand or divisor magnitude
    logic                is_div;
    logic                neg_res;   // sign_a ^ sign_b: product/quotient sign
    logic                neg_rem;   // remainder follows the dividend sign
    logic                mt_done;

    logic                sign_a;
    logic                sign_b;
    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;
    logic                div0_trap;

    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_step;
    logic [WIDTH:0]      trial;
    logic [WIDTH-1:0]    diff;
    logic [2*WIDTH-1:0]  div_step;

    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;

    assign sign_a = op_is_signed(md_op) & alu_a[WIDTH-1];
    assign sign_b = op_is_signed(md_op) & alu_b[WIDTH-1];

`ifdef MULDIV_DIV0_TRAP_EN
    assign div0_trap = op_is_div(md_op) && (alu_b == '0);
`else
    assign div0_trap = 1'b0;
`endif

    // Magnitudes are taken as unsigned, so the most-negative value maps to itself exactly.
    mod_muldiv_negate #(.W(WIDTH)) u_abs_a (.en(sign_a), .value(alu_a), .result(abs_a));
    mod_muldiv_negate #(.W(WIDTH)) u_abs_b (.en(sign_b), .value(alu_b), .result(abs_b));

    mod_muldiv_negate #(.W(2*WIDTH)) u_fix_prod (.en(neg_res), .value(acc),
                                                 .result(prod_fix));
    mod_muldiv_negate #(.W(WIDTH)) u_fix_quo (.en(neg_res), .value(acc[WIDTH-1:0]),
                                              .result(quo_fix));
    mod_muldiv_negate #(.W(WIDTH)) u_fix_rem (.en(neg_rem), .value(acc[2*WIDTH-1:WIDTH]),
                                              .result(rem_fix));

    // Shift-add: the multiplier drains out of the low half as the product fills in from the top.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shifted partial remainder is WIDTH+1 bits; when the trial
    // subtract succeeds the true difference is below the divisor, so WIDTH bits suffice.
    assign trial    = acc[2*WIDTH-1:WIDTH-1];
    assign diff     = trial[WIDTH-1:0] - opnd;
    assign div_step = (trial >= {1'b0, opnd}) ? {diff, acc[WIDTH-2:0], 1'b1}
                                              : {acc[2*WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && op_is_arith(md_op)) begin
                    state_nxt = div0_trap ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST_STEP) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Abort wins over everything, including a start in the same cycle.
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mt_done <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULDIV_DIV0_TRAP_EN
            div_zero <= 1'b0;
`endif
        end else begin
            mt_done <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
            div_zero <= 1'b0;
`endif
            if (!flush) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (op_is_arith(md_op)) begin
`ifdef MULDIV_DIV0_TRAP_EN
                                div_zero <= div0_trap;
`endif
                                if (!div0_trap) begin
                                    cnt     <= '0;
                                    is_div  <= op_is_div(md_op);
                                    neg_res <= sign_a ^ sign_b;
                                    neg_rem <= sign_a;
                                    acc     <= {{WIDTH{1'b0}},
                                                op_is_div(md_op) ? abs_a : abs_b};
                                    opnd    <= op_is_div(md_op) ? abs_b : abs_a;
                                end
                            end else if (md_op == MD_MTHI) begin
                                hi      <= alu_a;
                                mt_done <= 1'b1;
                            end else if (md_op == MD_MTLO) begin
                                lo      <= alu_a;
                                mt_done <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        cnt <= cnt + CNT_W'(1);
                        acc <= is_div ? div_step : mul_step;
                    end
                    ST_FIX: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE) || mt_done;

endmodule

// File: tb/tb_mod_muldiv_unit.sv
// Randomized + directed bench for mod_muldiv_unit against an arithmetic reference model.
module tb_mod_muldiv_unit;
    import pkg_muldiv::*;

    localparam int W = 32;
`ifdef MULDIV_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   md_op;
    logic         start;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MULDIV_DIV0_TRAP_EN
    logic         div_zero;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Architectural HI/LO as the model sees them.
    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    mod_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .md_op(md_op),
        .start(start),
        .flush(flush),
        .busy(busy),
        .done(done),
`ifdef MULDIV_DIV0_TRAP_EN
        .div_zero(div_zero),
`endif
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Updates hi_m/lo_m from the instruction semantics; lat = edges to done (0 = no done).
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = W + 2;
        dz  = 1'b0;
        case (op)
            3'd0: begin
                p = 64'(sa * sb);
                {hi_m, lo_m} = p;
            end
            3'd1: begin
                p = {32'b0, a} * {32'b0, b};
                {hi_m, lo_m} = p;
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    if (TRAP) begin
                        dz  = 1'b1;
                        lat = 1;
                    end else begin
                        hi_m = a;
                        lo_m = (op == 3'd2 && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
                    end
                end else if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    lo_m = 32'(q);
                    hi_m = 32'(r);
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            3'd4: begin hi_m = a; lat = 1; end
            3'd5: begin lo_m = a; lat = 1; end
            default: lat = 0;
        endcase
    endtask

    // Issues one op and waits for done; optionally pokes an MTHI request while busy.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        int lat, k, limit;
        bit dz, seen, busy_at_done, dz_at_done;
        model(op, a, b, lat, dz);
        limit = (lat == 0) ? 4 : 50;
        @(negedge clk);
        md_op = op; alu_a = a; alu_b = b; start = 1'b1;
        k = 0; seen = 1'b0; busy_at_done = 1'b0; dz_at_done = 1'b0;
        while (!seen && k < limit) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            start = 1'b0;
            if (poke && k == 5) begin
                md_op = MD_MTHI; alu_a = 32'hDEAD_BEEF; start = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                busy_at_done = busy;
`ifdef MULDIV_DIV0_TRAP_EN
                dz_at_done = div_zero;
`endif
            end
        end
        if (lat == 0) begin
            check({tag, "_nodone"}, 64'(seen), 64'd0);
            check({tag, "_busy"}, 64'(busy), 64'd0);
        end else begin
            check({tag, "_lat"}, 64'(k), 64'(lat));
            check({tag, "_busy"}, 64'(busy_at_done), 64'(op_is_arith(op)));
            if (TRAP) check({tag, "_dz"}, 64'(dz_at_done), 64'(dz));
        end
        check({tag, "_hi"}, 64'(hi), 64'(hi_m));
        check({tag, "_lo"}, 64'(lo), 64'(lo_m));
    endtask

    task automatic run_flush(input bit with_start);
        bit seen;
        @(negedge clk);
        md_op = MD_DIV; alu_a = 32'hFFFF_FF00; alu_b = 32'd9; start = 1'b1;
        if (!with_start) begin
            repeat (10) begin
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
            end
            check("flush_busy_before", 64'(busy), 64'd1);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check(with_start ? "flushstart_busy" : "flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(with_start ? "flushstart_nodone" : "flush_nodone", 64'(seen), 64'd0);
        check("flush_hi", 64'(hi), 64'(hi_m));
        check("flush_lo", 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        alu_a = '0; alu_b = '0; md_op = 3'd0;
        hi_m = '0; lo_m = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        run_op("mtlo", MD_MTLO, 32'hCAFE_0001, 32'd0, 1'b0);
        run_op("mult_minmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div0_pos", MD_DIV, 32'd5, 32'd0, 1'b0);
        run_op("divu0", MD_DIVU, 32'd5, 32'd0, 1'b0);
        run_op("div0_neg", MD_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("undef", 3'd6, 32'h5555_5555, 32'd1, 1'b0);
        run_op("busy_poke", MD_DIVU, 32'd1000, 32'd3, 1'b1);
        run_flush(1'b0);
        run_flush(1'b1);

        // Async reset in the middle of a multiply.
        @(negedge clk);
        md_op = MD_MULTU; alu_a = 32'd77; alu_b = 32'd91; start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("midrun_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op("rand", op, pick(), pick(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
